// File: rtl/pn_spreader.sv
// pn_spreader
// -----------------------------------------------------------------------------
// Direct-sequence spreading transmitter. A Fibonacci LFSR produces a
// free-running maximal-length PN chip stream (period P = 2^LFSR_WIDTH - 1
// chips, each chip lasting CHIP_DIV clocks). One data bit per full code
// period is XORed onto the chip stream to form the spread signal. An epoch
// strobe marks the first clock of chip 0 of every period, so a downstream
// chip correlator can use it as its dump/restart.
//
// Ports:
//   clk         system clock, everything on the rising edge
//   rst         synchronous reset, active-high
//   data        data bit to spread
//   data_valid  data holds a bit to transmit
//   data_ready  one-entry holding register is empty (transfer on valid&&ready)
//   code        current PN chip (lfsr[0])
//   sig         spread output: cur_bit ^ code while transmitting, else 0
//   epoch       one-clock pulse in the first clock of chip 0 of each period
//   tx_active   current period carries a data bit
//   underrun    one-clock pulse: period boundary while active with no bit held
// -----------------------------------------------------------------------------
module pn_spreader #(
  parameter int                    LFSR_WIDTH = 7,
  parameter logic [LFSR_WIDTH-1:0] TAPS       = 7'h03,
  parameter logic [LFSR_WIDTH-1:0] SEED       = 7'h01,
  parameter int                    CHIP_DIV   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic data,
  input  logic data_valid,
  output logic data_ready,
  output logic code,
  output logic sig,
  output logic epoch,
  output logic tx_active,
  output logic underrun
);

  localparam int DIV_W = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CHIP_DIV - 1);
  // Last chip index of a period: P-1 = 2^W - 2, i.e. all ones except bit 0.
  localparam logic [LFSR_WIDTH-1:0] IDX_LAST = {{(LFSR_WIDTH-1){1'b1}}, 1'b0};

  // The only "FSM" here: a period is either idle or carries one data bit.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                  state, state_next;
  logic [DIV_W-1:0]        div_q, div_next;
  logic [LFSR_WIDTH-1:0]   chip_idx, idx_next;
  logic [LFSR_WIDTH-1:0]   lfsr, lfsr_next;
  logic                    hold_full, hold_full_next;
  logic                    hold_bit, hold_bit_next;
  logic                    cur_bit, cur_bit_next;
  logic                    epoch_q, epoch_next;
  logic                    underrun_q, underrun_next;
  logic                    sig_q, sig_next;

  logic chip_tick;
  logic period_end;
  logic accept;
  logic fb;

  assign chip_tick  = (div_q == DIV_LAST);
  assign period_end = chip_tick && (chip_idx == IDX_LAST);
  assign accept     = data_valid && !hold_full;
  assign fb         = ^(lfsr & TAPS);

  assign data_ready = !hold_full;
  assign code       = lfsr[0];
  assign sig        = sig_q;
  assign epoch      = epoch_q;
  assign tx_active  = (state == SEND);
  assign underrun   = underrun_q;

  // Next-state logic for the chip timer, the LFSR, the idle/send state and
  // the holding register. At a period end the LFSR is reloaded with SEED and
  // the held bit (if any) becomes the bit for the new period, all on the same
  // edge, so the spread output lines up exactly with chip 0.
  // sig is computed from the *next* register values and stored, so the pin
  // comes straight from a flop and never glitches.
  always_comb begin
    state_next     = state;
    div_next       = div_q + DIV_W'(1);
    idx_next       = chip_idx;
    lfsr_next      = lfsr;
    hold_full_next = hold_full;
    hold_bit_next  = hold_bit;
    cur_bit_next   = cur_bit;
    epoch_next     = 1'b0;
    underrun_next  = 1'b0;

    if (chip_tick) begin
      div_next = '0;
      if (period_end) begin
        idx_next   = '0;
        lfsr_next  = SEED;
        epoch_next = 1'b1;
        if (hold_full) begin
          state_next     = SEND;
          cur_bit_next   = hold_bit;
          hold_full_next = 1'b0;
        end else begin
          state_next    = IDLE;
          underrun_next = (state == SEND);
        end
      end else begin
        idx_next  = chip_idx + LFSR_WIDTH'(1);
        lfsr_next = {fb, lfsr[LFSR_WIDTH-1:1]};
      end
    end

    // A new bit accepted in the same cycle as a boundary load is stored after
    // the old entry was consumed, so nothing is lost.
    if (accept) begin
      hold_full_next = 1'b1;
      hold_bit_next  = data;
    end

    sig_next = (state_next == SEND) && (cur_bit_next ^ lfsr_next[0]);
  end

  // State register. Reset discards both the held and the current bit and
  // restarts the code from chip 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div_q      <= '0;
      chip_idx   <= '0;
      lfsr       <= SEED;
      hold_full  <= 1'b0;
      hold_bit   <= 1'b0;
      cur_bit    <= 1'b0;
      epoch_q    <= 1'b0;
      underrun_q <= 1'b0;
      sig_q      <= 1'b0;
    end else begin
      state      <= state_next;
      div_q      <= div_next;
      chip_idx   <= idx_next;
      lfsr       <= lfsr_next;
      hold_full  <= hold_full_next;
      hold_bit   <= hold_bit_next;
      cur_bit    <= cur_bit_next;
      epoch_q    <= epoch_next;
      underrun_q <= underrun_next;
      sig_q      <= sig_next;
    end
  end

endmodule

// File: doc/pn_spreader.md
Name: pn_spreader

Overview:
- Direct-sequence spreading transmitter for the AM detector chain.
- Generates a free-running maximal-length PN chip sequence.
- XORs one data bit per full code period onto it (drives `sig`), emits the raw code, and emits an epoch strobe marking code-period boundaries.
- Sits upstream of the chip correlator: `code`/`sig`/`epoch` map directly onto the correlator's code, signal and dump/rst inputs.

Parameters:
- LFSR_WIDTH, 7, PN register width; code period P = 2^LFSR_WIDTH - 1 chips (127).
- TAPS, 7'h03, feedback mask; bit i set = lfsr[i] included in XOR feedback (default is maximal, x^7+x^6+1).
- SEED, 7'h01, LFSR state at chip 0 of every period; must be nonzero.
- CHIP_DIV, 4, clk cycles per chip; legal range 1..65535.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- data  in  1  data bit to spread
- data_valid  in  1  data holds a bit to transmit
- data_ready  out  1  holding register empty; transfer when data_valid && data_ready
- code  out  1  current PN chip, lfsr[0]
- sig  out  1  spread output: cur_bit ^ code when tx_active, else 0
- epoch  out  1  one-clk pulse in the first clk of chip 0 of each period
- tx_active  out  1  current period carries a data bit
- underrun  out  1  one-clk pulse: period boundary while active and no bit held

Behaviour:
- Reset: lfsr=SEED, div=0, chip_idx=0, hold_full=0, cur_bit=0, tx_active=0, epoch=0, underrun=0.
  - Outputs after reset: data_ready=1, code=SEED[0], sig=0.
  - The first period after reset is always idle.
- Chip timing:
  - div counts 0..CHIP_DIV-1 and wraps; chip_tick = (div==CHIP_DIV-1).
  - With CHIP_DIV=1, chip_tick is asserted every cycle.
- LFSR (Fibonacci, right shift):
  - On chip_tick: fb = ^(lfsr & TAPS); lfsr <= {fb, lfsr[N-1:1]}.
  - chip_idx increments 0..P-1.
- Period end (chip_tick && chip_idx==P-1):
  - chip_idx<=0 and lfsr<=SEED (forced reload; equals the natural next state for maximal taps).
  - epoch<=1 for exactly one clk.
- Boundary load, in the same cycle as the period end:
  - If hold_full: cur_bit<=hold_bit, tx_active<=1, hold_full<=0.
  - Else: tx_active<=0; underrun<=1 if tx_active was 1.
- Input handshake:
  - One-entry holding register; data_ready = !hold_full (combinational from the register).
  - Accept data when data_valid && data_ready; this sets hold_full.
  - If acceptance and a boundary load coincide, the boundary consumes the old entry and the new bit is stored. Net result: hold_full stays 1 and the bit is not lost.
  - While hold_full=1, data_valid is ignored.
- Output timing:
  - code, sig and tx_active change only at chip boundaries; sig is glitch-free registered logic.
  - cur_bit and tx_active switch in the same edge as lfsr reload, so sig is aligned to chip 0.
- Latency: a bit accepted during period k is transmitted in period k+1, or period k+2 if the holding register was already occupied.
- Reset mid-operation: the held bit and current bit are discarded; state returns to reset values on the next edge.
- No other state machine states: IDLE = !tx_active, SEND = tx_active, with transitions only at period boundaries.

Test Plan:
- Code sequence: reset, CHIP_DIV=1 → code chips 0..7 = 1,0,0,0,0,0,0,1; sequence repeats exactly every 127 clks; 64 ones per period.
- Epoch spacing: CHIP_DIV=4 → epoch high one clk every 508 clks; first pulse 508 clks after reset release; no other pulses.
- Spreading: present data=0 then data=1 back-to-back with valid held → tx_active rises at the first epoch. sig==code for all 127 chips of the first active period; sig==~code for the next. A correlator fed the same code and epoch reports 127 then 0.
- Handshake: assert data_valid continuously → data_ready drops one clk after each accept and rises only after the next epoch. Exactly one bit is consumed per period, none are dropped or duplicated; check 16 random bits.
- Underrun: send one bit then deassert data_valid → tx_active high for one period. Then underrun pulses once at the following epoch, tx_active=0 and sig=0 while code keeps running.
- Reset mid-period: assert rst at chip 50 of an active period → next cycle sig=0, tx_active=0, data_ready=1, code=1 (SEED). Epoch timing restarts from chip 0.
